// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
// Final pipeline stage ahead of the register bank write port. Retires one
// instruction per handshake: ALU result, link value (PC+4), load, or no write.
// Loads run a single-outstanding req/ack memory read. The returned word is
// lane-aligned and then sign- or zero-extended. An abandoned or faulting load
// raises a one-cycle load_err.
//
// Ports
//   clk, rst_h             clock, synchronous active-high reset
//   in_valid/in_ready      execute handshake (in_ready combinational)
//   in_kind                00 none, 01 ALU, 10 load, 11 link
//   in_rd                  destination register
//   in_result              ALU result or load byte address
//   in_pc                  instruction PC (link)
//   in_funct3              load size/sign selector
//   mem_req/mem_addr       registered word-aligned read request
//   mem_ack/mem_rdata      read completion and little-endian data
//   rd/write/write_data    registered one-cycle register bank write
//   load_err               registered one-cycle fault/timeout pulse
// -----------------------------------------------------------------------------
module writeback_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_h,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_result,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [4:0]  rd,
    output logic        write,
    output logic [31:0] write_data,
    output logic        load_err
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    // Counter value in the last MEM_WAIT cycle before the load is abandoned.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [4:0]  ld_rd_r;
    logic [2:0]  ld_funct3_r;
    logic [1:0]  ld_off_r;

    // Misaligned access or unsupported funct3 for a load.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
        logic fault_s;
        case (f3)
            3'b000, 3'b100: fault_s = 1'b0;
            3'b001, 3'b101: fault_s = off[0];
            3'b010:         fault_s = (off != 2'b00);
            default:        fault_s = 1'b1;
        endcase
        return fault_s;
    endfunction

    // Select the byte/half lane from the read word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] ext_s;
        byte_s = 8'(word >> {off, 3'b000});
        half_s = 16'(word >> {off[1], 4'b0000});
        case (f3)
            3'b000:  ext_s = {{24{byte_s[7]}}, byte_s};
            3'b001:  ext_s = {{16{half_s[15]}}, half_s};
            3'b010:  ext_s = word;
            3'b100:  ext_s = {24'd0, byte_s};
            3'b101:  ext_s = {16'd0, half_s};
            default: ext_s = 32'd0;
        endcase
        return ext_s;
    endfunction

    // Ready only when idle and not held in reset.
    assign in_ready = (state_r == ST_IDLE) && !rst_h;

    // Retire FSM: accept, issue the load, track the timeout, drive registered outputs.
    always_ff @(posedge clk) begin
        if (rst_h) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            ld_rd_r     <= 5'd0;
            ld_funct3_r <= 3'd0;
            ld_off_r    <= 2'd0;
            mem_req     <= 1'b0;
            mem_addr    <= 32'd0;
            rd          <= 5'd0;
            write       <= 1'b0;
            write_data  <= 32'd0;
            load_err    <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            write    <= 1'b0;
            load_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (in_kind)
                            2'b01: begin
                                write      <= (in_rd != 5'd0);
                                rd         <= in_rd;
                                write_data <= in_result;
                            end
                            2'b11: begin
                                write      <= (in_rd != 5'd0);
                                rd         <= in_rd;
                                write_data <= in_pc + 32'd4;
                            end
                            2'b10: begin
                                if (load_fault(in_funct3, in_result[1:0])) begin
                                    load_err <= 1'b1;
                                end else begin
                                    state_r     <= ST_MEM_WAIT;
                                    cnt_r       <= 8'd0;
                                    mem_req     <= 1'b1;
                                    mem_addr    <= {in_result[31:2], 2'b00};
                                    ld_rd_r     <= in_rd;
                                    ld_funct3_r <= in_funct3;
                                    ld_off_r    <= in_result[1:0];
                                end
                            end
                            default: begin
                                // kind 00: consumed with no architectural effect
                            end
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack on the expiry edge takes priority over the timeout.
                    if (mem_ack) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= 8'd0;
                        mem_req    <= 1'b0;
                        write      <= (ld_rd_r != 5'd0);
                        rd         <= ld_rd_r;
                        write_data <= load_extend(ld_funct3_r, ld_off_r, mem_rdata);
                    end else if (cnt_r == TO_LAST) begin
                        state_r  <= ST_IDLE;
                        cnt_r    <= 8'd0;
                        mem_req  <= 1'b0;
                        load_err <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboarded bench for writeback_unit. Stimulus tasks push the expected
// register-bank events (write or load_err, with the cycle they must appear in)
// into a queue. A monitor pops and compares whenever the DUT pulses an output.
module tb_writeback_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_h;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  rd;
    logic        write;
    logic [31:0] write_data;
    logic        load_err;

    writeback_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_h(rst_h), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_result(in_result), .in_pc(in_pc),
        .in_funct3(in_funct3), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rd(rd), .write(write),
        .write_data(write_data), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [4:0]  rd;
        logic [31:0] data;
        int          stamp;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_fault(input int unsigned f3, input int unsigned addr);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
        if ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) return 1'b1;
        if (f3 == 2 && (addr % 4 != 0)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int unsigned f3, input int unsigned addr,
                                               input int unsigned word);
        int unsigned off;
        int unsigned b;
        int unsigned h;
        off = addr % 4;
        b = (word >> (8 * off)) % 256;
        h = (word >> (16 * (off / 2))) % 65536;
        case (f3)
            0: return (b >= 128) ? b - 256 : b;
            1: return (h >= 32768) ? h - 65536 : h;
            2: return word;
            4: return b;
            5: return h;
            default: return 32'd0;
        endcase
    endfunction

    task automatic push_write(input logic [4:0] r, input logic [31:0] d, input int stamp);
        exp_t e;
        if (r != 5'd0) begin
            e.is_err = 1'b0; e.rd = r; e.data = d; e.stamp = stamp;
            sb.push_back(e);
        end
    endtask

    task automatic push_err(input int stamp);
        exp_t e;
        e.is_err = 1'b1; e.rd = 5'd0; e.data = 32'd0; e.stamp = stamp;
        sb.push_back(e);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (write === 1'b1 || load_err === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: write=%b load_err=%b rd=%0d data=%h cycle %0d, expected none",
                         write, load_err, rd, write_data, cyc);
            end else begin
                e = sb.pop_front();
                check32("evt_load_err", {31'd0, load_err}, {31'd0, e.is_err});
                check32("evt_write", {31'd0, write}, {31'd0, ~e.is_err});
                check32("evt_cycle", cyc, e.stamp);
                if (!e.is_err) begin
                    check32("evt_rd", {27'd0, rd}, {27'd0, e.rd});
                    check32("evt_data", write_data, e.data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic release_in();
        in_valid  = 1'b0;
        in_kind   = 2'b00;
        in_rd     = 5'd0;
        in_result = 32'd0;
        in_pc     = 32'd0;
        in_funct3 = 3'd0;
    endtask

    // Non-load op issued at the current negedge; accepted at the next posedge.
    task automatic alu_op(input logic [1:0] kind, input logic [4:0] r, input logic [31:0] val);
        check32("in_ready_alu", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_rd     = r;
        in_result = val;
        in_pc     = val;
        in_funct3 = 3'($urandom_range(7, 0));
        if (kind == 2'b01) push_write(r, val, cyc + 1);
        if (kind == 2'b11) push_write(r, 32'(val + 32'd4), cyc + 1);
        tick();
        release_in();
    endtask

    // Load op; delay = cycles of mem_req before ack is sampled, 0 = never ack.
    task automatic do_load(input logic [4:0] r, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input int delay);
        int a;
        check32("in_ready_load", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_kind   = 2'b10;
        in_rd     = r;
        in_result = addr;
        in_pc     = $urandom;
        in_funct3 = f3;
        a = cyc + 1;
        if (model_fault(f3, addr)) begin
            push_err(a);
            tick();
            release_in();
            check32("fault_no_req", {31'd0, mem_req}, 32'd0);
            check32("fault_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            tick();
            release_in();
            for (int k = 0; k < TO; k++) begin
                check32("req_high", {31'd0, mem_req}, 32'd1);
                check32("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
                check32("busy_ready", {31'd0, in_ready}, 32'd0);
                if (delay != 0 && k == delay - 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word;
                    push_write(r, model_load(f3, addr, word), a + delay);
                    tick();
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                    break;
                end
                if (k == TO - 1) begin
                    push_err(a + TO);
                    tick();
                end else begin
                    tick();
                end
            end
            check32("done_req_low", {31'd0, mem_req}, 32'd0);
            check32("done_ready", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int kind;
        rst_h     = 1'b1;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        release_in();
        tick();
        tick();
        check32("rst_write", {31'd0, write}, 32'd0);
        check32("rst_rd", {27'd0, rd}, 32'd0);
        check32("rst_wdata", write_data, 32'd0);
        check32("rst_load_err", {31'd0, load_err}, 32'd0);
        check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_in_ready", {31'd0, in_ready}, 32'd0);
        rst_h = 1'b0;
        tick();

        // ALU back-to-back, link wrap, kind none
        alu_op(2'b01, 5'd5, 32'h1234_5678);
        alu_op(2'b01, 5'd6, 32'hDEAD_BEEF);
        alu_op(2'b11, 5'd1, 32'hFFFF_FFFC);
        alu_op(2'b11, 5'd2, 32'h0000_0100);
        alu_op(2'b00, 5'd7, 32'h5555_AAAA);
        alu_op(2'b01, 5'd0, 32'h0BAD_F00D);

        // Load extension from word 0x80FF7F01 at 0x40, ack after 3 cycles
        do_load(5'd10, 32'h41, 3'b000, 32'h80FF_7F01, 3);
        do_load(5'd11, 32'h43, 3'b000, 32'h80FF_7F01, 3);
        do_load(5'd12, 32'h42, 3'b100, 32'h80FF_7F01, 3);
        do_load(5'd13, 32'h42, 3'b001, 32'h80FF_7F01, 3);
        do_load(5'd14, 32'h40, 3'b010, 32'h80FF_7F01, 3);
        do_load(5'd15, 32'h42, 3'b101, 32'h80FF_7F01, 1);

        // Faults
        do_load(5'd3, 32'h42, 3'b010, 32'd0, 1);
        do_load(5'd3, 32'h41, 3'b001, 32'd0, 1);
        do_load(5'd3, 32'h40, 3'b011, 32'd0, 1);

        // Timeout, then a stray ack while idle
        do_load(5'd9, 32'h80, 3'b010, 32'd0, 0);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        tick();
        mem_ack = 1'b0;
        tick();

        // Ack on the expiry edge wins; rd=0 load still requests memory
        do_load(5'd16, 32'h88, 3'b010, 32'h1357_9BDF, TO);
        do_load(5'd0, 32'h44, 3'b010, 32'h2468_ACE0, 2);

        // Reset mid-load
        check32("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_kind   = 2'b10;
        in_rd     = 5'd20;
        in_result = 32'h100;
        in_funct3 = 3'b010;
        tick();
        release_in();
        check32("rst_mid_req", {31'd0, mem_req}, 32'd1);
        tick();
        rst_h = 1'b1;
        tick();
        check32("rst_mid_req_low", {31'd0, mem_req}, 32'd0);
        check32("rst_mid_write", {31'd0, write}, 32'd0);
        check32("rst_mid_err", {31'd0, load_err}, 32'd0);
        check32("rst_mid_addr", mem_addr, 32'd0);
        check32("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        rst_h = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        tick();
        tick();

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            kind = $urandom_range(3, 0);
            if (kind == 2) begin
                do_load(5'($urandom_range(31, 0)), $urandom, 3'($urandom_range(7, 0)),
                        $urandom, $urandom_range(TO, 0));
            end else begin
                alu_op(2'(kind), 5'($urandom_range(31, 0)), $urandom);
            end
            if ($urandom_range(3, 0) == 0) tick();
        end

        tick();
        tick();
        tick();
        check32("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
